// File: rtl/lzrw1_pkg.sv
// Shared types for the LZRW1 item unpacker.
// FSM states, item bundle and control-byte constants.
package lzrw1_pkg;

  typedef enum logic [2:0] {
    CTRL,
    B0,
    B1,
    EMIT,
    DONE
  } unpack_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        is_copy;
  } lzrw1_item_t;

  localparam int         CONTROL_BITS = 8;
  localparam logic [7:0] LITERAL_PAD  = 8'h00;

endpackage

// File: rtl/lzrw1_item_unpacker.sv
// Splits an LZRW1 byte stream into literal/copy items
// and hands them to the decompressor over valid/busy.
module lzrw1_item_unpacker
  import lzrw1_pkg::*;
#(
  parameter int ITEM_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_in_valid,
  input  logic                        byte_in_last,
  output logic                        byte_in_ready,
  output logic [15:0]                 data_out,
  output logic                        control_word_out,
  output logic                        data_out_valid,
  input  logic                        decompressor_busy,
  output logic                        block_done,
  output logic                        format_error,
  output logic [ITEM_COUNT_WIDTH-1:0] items_emitted
);

  localparam logic [ITEM_COUNT_WIDTH-1:0] CNT_ONE =
    {{(ITEM_COUNT_WIDTH-1){1'b0}}, 1'b1};

  unpack_state_t state;
  lzrw1_item_t   item;
  logic [7:0]    ctrl_sr;
  logic [7:0]    hi_byte;
  logic [3:0]    bits_left;
  logic          last_seen;
  logic          clear_pending;
  logic          accepting;
  logic          byte_xfer;
  logic          item_xfer;

  // Ready is forced low while reset is held so every output reads 0.
  assign accepting     = (state == CTRL) || (state == B0) || (state == B1);
  assign byte_in_ready = accepting & reset;
  assign data_out_valid = (state == EMIT);
  assign block_done     = (state == DONE);
  assign data_out         = item.data;
  assign control_word_out = item.is_copy;

  assign byte_xfer = byte_in_valid & byte_in_ready;
  assign item_xfer = data_out_valid & ~decompressor_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= CTRL;
      item          <= '0;
      ctrl_sr       <= '0;
      hi_byte       <= '0;
      bits_left     <= '0;
      last_seen     <= 1'b0;
      clear_pending <= 1'b0;
      format_error  <= 1'b0;
      items_emitted <= '0;
    end else begin
      unique case (state)
        CTRL: if (byte_xfer) begin
          ctrl_sr   <= byte_in;
          bits_left <= 4'(CONTROL_BITS);
          if (clear_pending) begin
            items_emitted <= '0;
            format_error  <= 1'b0;
            last_seen     <= 1'b0;
            clear_pending <= 1'b0;
          end
          state <= byte_in_last ? DONE : B0;
        end
        B0: if (byte_xfer) begin
          bits_left <= bits_left - 4'd1;
          if (!ctrl_sr[7]) begin
            item      <= '{data: {LITERAL_PAD, byte_in}, is_copy: 1'b0};
            last_seen <= byte_in_last;
            state     <= EMIT;
          end else if (byte_in_last) begin
            // Copy item truncated by end of block: drop it.
            format_error <= 1'b1;
            state        <= DONE;
          end else begin
            hi_byte   <= byte_in;
            last_seen <= byte_in_last;
            state     <= B1;
          end
        end
        B1: if (byte_xfer) begin
          item      <= '{data: {hi_byte, byte_in}, is_copy: 1'b1};
          last_seen <= byte_in_last;
          state     <= EMIT;
        end
        EMIT: if (item_xfer) begin
          if (items_emitted != '1)
            items_emitted <= items_emitted + CNT_ONE;
          ctrl_sr <= {ctrl_sr[6:0], 1'b0};
          if (last_seen)
            state <= DONE;
          else if (bits_left == 4'd0)
            state <= CTRL;
          else
            state <= B0;
        end
        DONE: begin
          clear_pending <= 1'b1;
          state         <= CTRL;
        end
        default: state <= CTRL;
      endcase
    end
  end

endmodule

// File: doc/lzrw1_item_unpacker.md
Name: lzrw1_item_unpacker

Overview:
- Upstream feeder for the decompressor core.
- Takes the compressed block as a flat byte stream: one control byte, then up to 8 items, repeated.
- Splits the stream into items of {data_in[15:0], control_word_in} and presents them using the decompressor's valid/busy handshake.
- Sits between the compressed-data source (FIFO/DMA) and decompressor_top.

Parameters:
- ITEM_COUNT_WIDTH, 16, width of the per-block emitted-item counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- byte_in  input  8  compressed stream byte.
- byte_in_valid  input  1  byte_in is valid.
- byte_in_last  input  1  byte_in is the final byte of the block; qualified by byte_in_valid.
- byte_in_ready  output  1  unpacker accepts byte_in this cycle.
- data_out  output  16  item payload; drives decompressor data_in.
- control_word_out  output  1  1 = copy item, 0 = literal; drives control_word_in.
- data_out_valid  output  1  item is presented; drives data_in_valid.
- decompressor_busy  input  1  from decompressor; item not accepted while high.
- block_done  output  1  one-cycle pulse when block processing ends.
- format_error  output  1  sticky; block ended in the middle of a copy item.
- items_emitted  output  ITEM_COUNT_WIDTH  items accepted by the decompressor in the current block.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state CTRL, control shift register 0, bit counter 0. Any partial item or presented item is discarded.
- Byte transfer: occurs when byte_in_valid && byte_in_ready at a rising edge.
- Item transfer: occurs when data_out_valid && !decompressor_busy at a rising edge.
- Control byte bit order: bit 7 is consumed first, bit 0 last. 1 = copy (2 bytes), 0 = literal (1 byte).
- Item encoding:
  - Copy: first byte is data_out[15:8], second byte is data_out[7:0].
  - Literal: data_out = {8'h00, byte}.
- States:
  - CTRL: byte_in_ready=1. On transfer, load the control byte and set bits_left=8. If last=1, go to DONE (empty block); else go to B0.
  - B0: byte_in_ready=1. On transfer, take the current control bit.
    - Literal: form the item and go to EMIT.
    - Copy, last=0: latch the high byte and go to B1.
    - Copy, last=1: set format_error=1, discard, go to DONE.
    - In all non-error cases, record last into last_seen.
  - B1: byte_in_ready=1. On transfer, form the copy item, record last_seen, go to EMIT.
  - EMIT: byte_in_ready=0, data_out_valid=1. data_out and control_word_out stay stable until the item transfer. On transfer:
    - items_emitted increments (saturating at all-ones) and the control shift advances.
    - Next state: last_seen → DONE; else bits_left==0 → CTRL; else → B0.
    - data_out_valid may stay high the next cycle only with a new item. It never re-presents the same item.
  - DONE: byte_in_ready=0. block_done=1 for exactly one cycle, then go to CTRL.
- Per-block clearing: items_emitted, format_error and last_seen clear on the first byte transfer in CTRL after DONE. items_emitted stays readable through the block_done cycle.
- Latency: a byte transfer in B0/B1 gives data_out_valid=1 on the next cycle.
- Throughput: at most one item per 2 cycles (literal) or 3 cycles (copy) while decompressor_busy=0.
- Unused control bits after last_seen are ignored.
- Busy stuck high: the unpacker holds in EMIT indefinitely with no timeout.
- byte_in_last with byte_in_valid=0 is ignored.

Decomposition:
- Shared package lzrw1_pkg holds:
  - typedef enum unpack_state_t {CTRL, B0, B1, EMIT, DONE};
  - typedef struct packed {logic [15:0] data; logic is_copy;} lzrw1_item_t;
  - constants CONTROL_BITS=8 and LITERAL_PAD=8'h00.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Stream 8'h00 (control), 8'h41, 8'h42 (last), busy=0 → items {0041,0},{0042,0} in order; block_done pulse; items_emitted=2; format_error=0.
- Stream 8'h80, 8'h12, 8'h34, 8'h43 (last) → item {1234,1} then {0043,0}; data_out_valid rises exactly one cycle after the 8'h34 transfer.
- Hold busy=1 for 5 cycles while the first item is presented → data_out stays stable, byte_in_ready=0, and exactly one item transfer occurs after busy falls.
- 17 literals (control 8'h00, 8 literals, 8'h00, 8 literals, 8'h00, 1 literal last) → 17 items; items_emitted=17; every 9th byte is consumed as a control byte.
- Stream 8'h80, 8'hAB (last) → no item emitted; format_error=1; block_done pulses; the next block clears format_error on its first byte.
- Drive reset low during EMIT of a copy item → all outputs 0 asynchronously. After release, a new block 8'h00, 8'h5A (last) yields a single item {005A,0}.
